// File: rtl/inst_fetch_stage_pkg.sv
// Shared types for the MIPS IF stage: next-PC select encodings and the fetch buffer entry.
package inst_fetch_stage_pkg;

  typedef enum logic [2:0] {
    PC_NEXT     = 3'd0,
    PC_JUMP     = 3'd1,
    PC_BRANCH   = 3'd2,
    PC_FWD_DATA = 3'd3
  } pc_src_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory fetch port: single outstanding req/ack, rdata valid in the ack cycle.
interface inst_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/inst_fetch_stage_fetch_fifo.sv
// Fetch buffer between instruction memory and ID: power-of-2 depth, synchronous flush.
module fetch_fifo
  import inst_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  // NOTE: the storage array is deliberately not reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The issue rule keeps count + outstanding <= DEPTH, so a push into a full buffer is a bug.
  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !do_pop && !flush_i));

endmodule

// File: rtl/inst_fetch_stage.sv
// MIPS IF stage: PC ownership, next-PC redirect mux, fetch FSM and output buffer.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_rst,
  input  logic               if_en,
  input  logic               id_en,
  input  pc_src_e            pc_src,
  input  logic [31:0]        jump_target,
  input  logic [31:0]        branch_target,
  input  logic [31:0]        fwd_target,
  input  logic               irq_jump_en,
  input  logic [31:0]        irq_target,
  inst_fetch_stage_if.master imem,
  output logic [31:0]        inst_out,
  output logic [31:0]        pc_out,
  output logic               if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_KILL = 2'd2} state_e;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d, redirect_pc;
  logic [31:0]   fetch_addr;
  logic          redirect, flush, issue, fetch_req, push, pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;

  assign redirect = irq_jump_en || ((pc_src != PC_NEXT) && id_en && if_valid);
  assign flush    = redirect || if_rst;
  assign pop      = id_en && if_valid;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    if (irq_jump_en)                 redirect_pc = irq_target;
    else if (pc_src == PC_FWD_DATA)  redirect_pc = fwd_target;
    else if (pc_src == PC_BRANCH)    redirect_pc = branch_target;
    else                             redirect_pc = jump_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (issue && !imem.ack) state_d = S_WAIT;
      S_WAIT:  if (imem.ack) state_d = S_IDLE;
               else if (redirect) state_d = S_KILL;
      S_KILL:  if (imem.ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (if_rst) state_d = S_IDLE;

    fetch_pc_d = fetch_pc_q;
    if (if_rst)        fetch_pc_d = RESET_PC;
    else if (redirect) fetch_pc_d = redirect_pc;
    else if (push)     fetch_pc_d = pc_incr(fetch_pc_q);

    req_addr_d = issue ? fetch_pc_q : req_addr_q;
    if (if_rst) req_addr_d = RESET_PC;
  end

  // Gating issue with rst_n keeps imem.req low for the whole reset window, not just after an edge.
  always_comb begin
    issue      = rst_n && (state_q == S_IDLE) && if_en && (fifo_count < CW'(FIFO_DEPTH)) && !flush;
    fetch_req  = issue || (state_q == S_WAIT) || (state_q == S_KILL);
    fetch_addr = (state_q == S_IDLE) ? fetch_pc_q : req_addr_q;
    push       = fetch_req && imem.ack && (state_q != S_KILL) && !flush;
  end

  assign imem.req  = fetch_req;
  assign imem.addr = fetch_addr;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fetch_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ('{inst: imem.rdata, pc: fetch_addr}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign if_valid = !fifo_empty;
  assign inst_out = if_valid ? head.inst : 32'h0;
  assign pc_out   = if_valid ? head.pc   : 32'h0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (if_rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != 32'hFFFF_FFFF))                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (if_valid && !id_en && (stall_cnt_q != 32'hFFFF_FFFF))   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with a latency-programmable instruction memory model.
module tb_inst_fetch_stage;
  import inst_fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n, if_rst, if_en, id_en, irq_jump_en;
  pc_src_e     pc_src;
  logic [31:0] jump_target, branch_target, fwd_target, irq_target;
  logic [31:0] inst_out, pc_out;
  logic        if_valid;

  int unsigned mem_lat;
  int unsigned wait_cnt;
  logic        mem_block, force_ack;
  int          n_assert, n_fail;

  inst_fetch_stage_if imem_if ();

  inst_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_rst        (if_rst),
    .if_en         (if_en),
    .id_en         (id_en),
    .pc_src        (pc_src),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .fwd_target    (fwd_target),
    .irq_jump_en   (irq_jump_en),
    .irq_target    (irq_target),
    .imem          (imem_if),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .if_valid      (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word is its address XOR a fixed tag, so inst and pc differ.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_if.ack   = (imem_if.req && !mem_block && (wait_cnt >= mem_lat)) || force_ack;
  assign imem_if.rdata = mem_word(imem_if.addr);

  always @(posedge clk) begin
    if (!imem_if.req || imem_if.ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    wait_cnt = 0;
    rst_n = 1'b1; if_rst = 1'b0; if_en = 1'b1; id_en = 1'b1;
    pc_src = PC_NEXT; jump_target = '0; branch_target = '0; fwd_target = '0;
    irq_jump_en = 1'b0; irq_target = '0;
    mem_lat = 0; mem_block = 1'b0; force_ack = 1'b0;

    // Reset state, with if_en already high
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", imem_if.req, 0);
    check("rst_addr", imem_if.addr, 32'h0);
    check("rst_valid", if_valid, 0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("first_req", imem_if.req, 1);
    check("first_addr", imem_if.addr, 32'h0);
    check("first_valid", if_valid, 0);

    // Zero-wait streaming
    cyc();
    check("s0_valid", if_valid, 1);
    check("s0_pc", pc_out, 32'h0);
    check("s0_inst", inst_out, mem_word(32'h0));
    check("s0_addr", imem_if.addr, 32'h4);
    cyc();
    check("s1_pc", pc_out, 32'h4);
    check("s1_inst", inst_out, mem_word(32'h4));
    cyc();
    check("s2_pc", pc_out, 32'h8);
    check("s2_addr", imem_if.addr, 32'hC);

    // ID stall: buffer fills to two entries, then requests stop
    id_en = 1'b0;
    cyc();
    check("stall_req", imem_if.req, 0);
    check("stall_pc", pc_out, 32'h8);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_hold_req", imem_if.req, 0);
      check("stall_hold_pc", pc_out, 32'h8);
    end
    id_en = 1'b1;
    #1;
    check("unstall_full_req", imem_if.req, 0);
    cyc();
    check("unstall_pc_c", pc_out, 32'hC);
    check("unstall_inst_c", inst_out, mem_word(32'hC));
    check("unstall_addr", imem_if.addr, 32'h10);
    cyc();
    check("unstall_pc_10", pc_out, 32'h10);

    // Branch while a 2-wait fetch is outstanding
    mem_lat = 2; id_en = 1'b0;
    #1;
    cyc();
    check("wait_req", imem_if.req, 1);
    check("wait_addr", imem_if.addr, 32'h14);
    check("wait_pc", pc_out, 32'h10);
    pc_src = PC_BRANCH; branch_target = 32'h100; id_en = 1'b1;
    #1;
    cyc();
    pc_src = PC_NEXT;
    #1;
    check("kill_valid", if_valid, 0);
    check("kill_req_held", imem_if.req, 1);
    check("kill_addr_held", imem_if.addr, 32'h14);
    cyc();
    check("kill_drop_valid", if_valid, 0);
    check("br_req", imem_if.req, 1);
    check("br_addr", imem_if.addr, 32'h100);
    mem_lat = 0;
    #1;
    cyc();
    check("br_valid", if_valid, 1);
    check("br_pc", pc_out, 32'h100);
    check("br_inst", inst_out, mem_word(32'h100));

    // IRQ beats a simultaneous jump
    irq_jump_en = 1'b1; irq_target = 32'h180;
    pc_src = PC_JUMP; jump_target = 32'h40;
    #1;
    check("irq_no_issue", imem_if.req, 0);
    cyc();
    irq_jump_en = 1'b0; pc_src = PC_NEXT;
    #1;
    check("irq_valid", if_valid, 0);
    check("irq_req", imem_if.req, 1);
    check("irq_addr", imem_if.addr, 32'h180);
    cyc();
    check("irq_pc", pc_out, 32'h180);

    // JR forwarded target beats branch and jump targets
    pc_src = PC_FWD_DATA; fwd_target = 32'h200; branch_target = 32'h300; jump_target = 32'h40;
    #1;
    cyc();
    pc_src = PC_NEXT;
    #1;
    check("jr_addr", imem_if.addr, 32'h200);
    cyc();
    check("jr_pc", pc_out, 32'h200);
    check("jr_valid", if_valid, 1);

    // if_rst while a fetch is outstanding; the late ack must be ignored
    id_en = 1'b0; mem_block = 1'b1;
    #1;
    check("ifrst_pre_addr", imem_if.addr, 32'h204);
    cyc();
    check("ifrst_pre_pc", pc_out, 32'h200);
    if_rst = 1'b1;
    #1;
    cyc();
    if_rst = 1'b0; if_en = 1'b0;
    #1;
    check("ifrst_valid", if_valid, 0);
    check("ifrst_pc", pc_out, 32'h0);
    check("ifrst_inst", inst_out, 32'h0);
    check("ifrst_req", imem_if.req, 0);
    check("ifrst_addr", imem_if.addr, 32'h0);
    mem_block = 1'b0; force_ack = 1'b1;
    #1;
    cyc();
    force_ack = 1'b0;
    #1;
    check("late_ack_dropped", if_valid, 0);
    if_en = 1'b1; id_en = 1'b1;
    #1;
    check("ifrst_next_req", imem_if.req, 1);
    check("ifrst_next_addr", imem_if.addr, 32'h0);
    cyc();
    check("ifrst_next_pc", pc_out, 32'h0);
    check("ifrst_next_inst", inst_out, mem_word(32'h0));
    check("ifrst_next_valid", if_valid, 1);

    // Asynchronous reset in the middle of a pending fetch
    id_en = 1'b0; mem_block = 1'b1;
    #1;
    cyc();
    check("arst_pre_valid", if_valid, 1);
    check("arst_pre_req", imem_if.req, 1);
    check("arst_pre_addr", imem_if.addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", imem_if.req, 0);
    check("arst_valid", if_valid, 0);
    check("arst_inst", inst_out, 32'h0);
    check("arst_pc", pc_out, 32'h0);
    check("arst_addr", imem_if.addr, 32'h0);

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
